// File: rtl/fib_stream_gen.sv
// Fibonacci term generator with a valid/ready output stream; LANES terms per beat.
// Define FIB_STREAM_SATURATE_EN to saturate the first overflowed beat and stop after it.
module fib_stream_gen #(
    parameter int W     = 16,
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         seed_a,
    input  logic [W-1:0]         seed_b,
    input  logic [CNT_W-1:0]     len,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [LANES*W-1:0]   out_num,
    output logic                 overflow,
    output logic                 done
);

    // state | meaning
    // IDLE  | after reset, waiting for start
    // RUN   | presenting beats; start ignored
    // DONE  | last beat accepted, done=1, waiting for start
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef FIB_STREAM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    state_t               state, state_nxt;
    logic [W-1:0]         nxt_a, nxt_b;
    logic                 nxt_ta, nxt_tb;
    logic [CNT_W-1:0]     cnt, len_q;
    logic                 load, xfer, last_beat;
    logic [W-1:0]         base_a, base_b;
    logic                 base_ta, base_tb;
    logic [W-1:0]         term  [LANES+2];
    logic                 taint [LANES+2];
    logic [W:0]           sum;
    logic [LANES*W-1:0]   beat;
    logic                 beat_ovf;

    assign out_valid = (state == RUN);
    assign load      = start && (state != RUN);
    assign xfer      = out_valid && out_ready;
    assign last_beat = ((len_q != '0) && (cnt == len_q - CNT_W'(1))) || (SAT && overflow);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (xfer && last_beat) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // One adder chain serves both the seed load and every following beat.
    assign base_a  = load ? seed_a : nxt_a;
    assign base_b  = load ? seed_b : nxt_b;
    assign base_ta = load ? 1'b0   : nxt_ta;
    assign base_tb = load ? 1'b0   : nxt_tb;

    // taint marks a term whose true value has left the W-bit range at some point in its history
    always_comb begin
        term     = '{default: '0};
        taint    = '{default: 1'b0};
        sum      = '0;
        term[0]  = base_a;
        term[1]  = base_b;
        taint[0] = base_ta;
        taint[1] = base_tb;
        for (int k = 2; k < LANES + 2; k++) begin
            sum      = {1'b0, term[k-2]} + {1'b0, term[k-1]};
            term[k]  = sum[W-1:0];
            taint[k] = sum[W] | taint[k-1] | taint[k-2];
        end
    end

    always_comb begin
        beat     = '0;
        beat_ovf = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            beat[i*W +: W] = (SAT && taint[i]) ? {W{1'b1}} : term[i];
            beat_ovf       = beat_ovf | taint[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_num  <= '0;
            nxt_a    <= '0;
            nxt_b    <= '0;
            nxt_ta   <= 1'b0;
            nxt_tb   <= 1'b0;
            cnt      <= '0;
            len_q    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else if (load) begin
            out_num  <= beat;
            nxt_a    <= term[LANES];
            nxt_b    <= term[LANES+1];
            nxt_ta   <= taint[LANES];
            nxt_tb   <= taint[LANES+1];
            cnt      <= '0;
            len_q    <= len;
            overflow <= beat_ovf;
            done     <= 1'b0;
        end else if (xfer) begin
            cnt <= cnt + CNT_W'(1);
            if (last_beat) begin
                done <= 1'b1;
            end else begin
                out_num  <= beat;
                nxt_a    <= term[LANES];
                nxt_b    <= term[LANES+1];
                nxt_ta   <= taint[LANES];
                nxt_tb   <= taint[LANES+1];
                overflow <= overflow | beat_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fib_stream_gen.sv
// Bench for fib_stream_gen: directed scenarios plus randomized runs against a term-by-term model.
module tb_fib_stream_gen;
    localparam int W     = 16;
    localparam int LANES = 2;
    localparam int CNT_W = 16;
    localparam longint LIM = longint'(1) << W;
`ifdef FIB_STREAM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [W-1:0]         seed_a, seed_b;
    logic [CNT_W-1:0]     len;
    logic                 out_ready;
    logic                 out_valid;
    logic [LANES*W-1:0]   out_num;
    logic                 overflow;
    logic                 done;

    fib_stream_gen #(.W(W), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .seed_a(seed_a), .seed_b(seed_b),
        .len(len), .out_ready(out_ready), .out_valid(out_valid), .out_num(out_num),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    bit chk_en   = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input logic [LANES*W-1:0] act, input logic [LANES*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Term k of the sequence from seeds a,b: wrapped value and whether its true value reached 2^W.
    function automatic void fib_term(input logic [W-1:0] a, input logic [W-1:0] b, input int k,
                                     output logic [W-1:0] v, output bit ov);
        longint x, y, z;
        logic [W-1:0] wx, wy, wz;
        x = longint'(a); y = longint'(b); wx = a; wy = b;
        if (k == 0) begin
            v = wx; ov = 1'b0;
            return;
        end
        for (int i = 2; i <= k; i++) begin
            z = x + y;
            if (z > LIM) z = LIM;
            wz = wx + wy;
            x = y; y = z; wx = wy; wy = wz;
        end
        v  = wy;
        ov = (y >= LIM);
    endfunction

    function automatic logic [LANES*W-1:0] exp_beat(input logic [W-1:0] a, input logic [W-1:0] b, input int j);
        logic [LANES*W-1:0] r;
        logic [W-1:0] v;
        bit ov;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            fib_term(a, b, j*LANES + i, v, ov);
            if (SAT && ov) v = '1;
            r[i*W +: W] = v;
        end
        return r;
    endfunction

    function automatic bit beat_ov(input logic [W-1:0] a, input logic [W-1:0] b, input int j);
        logic [W-1:0] v;
        bit ov, any;
        any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            fib_term(a, b, j*LANES + i, v, ov);
            any = any | ov;
        end
        return any;
    endfunction

    function automatic logic [LANES*W-1:0] pack2(input int l0, input int l1);
        logic [W-1:0] a, b;
        a = W'(l0);
        b = W'(l1);
        return {b, a};
    endfunction

    // Model: 0 idle, 1 running, 2 finished; m_j = index of the beat currently presented.
    int               m_st;
    logic [W-1:0]     m_a, m_b;
    logic [CNT_W-1:0] m_len;
    int               m_j;
    bit               m_ovf;
    bit               m_last_ov;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st = 0; m_j = 0; m_ovf = 1'b0;
        end else if (m_st == 1) begin
            if (out_ready) begin
                m_last_ov = beat_ov(m_a, m_b, m_j);
                m_j++;
                if ((m_len != '0 && m_j == int'(m_len)) || (SAT && m_last_ov))
                    m_st = 2;
                else
                    m_ovf = m_ovf | beat_ov(m_a, m_b, m_j);
            end
        end else if (start) begin
            m_st  = 1;
            m_a   = seed_a;
            m_b   = seed_b;
            m_len = len;
            m_j   = 0;
            m_ovf = beat_ov(seed_a, seed_b, 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check1("model_valid", out_valid, m_st == 1);
            if (m_st == 1) checkn("model_num", out_num, exp_beat(m_a, m_b, m_j));
            check1("model_overflow", overflow, m_ovf);
            check1("model_done", done, m_st == 2);
        end
    end

    always @(posedge clk) if (rst && out_valid && out_ready) n_xfer++;

    task automatic pulse_start(input int a, input int b, input int l);
        @(negedge clk);
        start = 1'b1; seed_a = W'(a); seed_b = W'(b); len = CNT_W'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check1("done_reached", done, 1'b1);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check1("rst_valid", out_valid, 1'b0);
        checkn("rst_num", out_num, '0);
        check1("rst_overflow", overflow, 1'b0);
        check1("rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int basic_exp [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};

    initial begin
        logic [W-1:0] v;
        bit ov;
        rst = 1'b0; start = 1'b0; seed_a = '0; seed_b = '0; len = '0; out_ready = 1'b0;
        #1;
        check1("init_valid", out_valid, 1'b0);
        checkn("init_num", out_num, '0);
        fib_term(16'd1, 16'd1, 22, v, ov);
        checki("pin_t22", int'(v), 28657);
        check1("pin_t22_ov", ov, 1'b0);
        fib_term(16'd1, 16'd1, 24, v, ov);
        checki("pin_t24", int'(v), 9489);
        check1("pin_t24_ov", ov, 1'b1);
        fib_term(16'd1, 16'd1, 25, v, ov);
        checki("pin_t25", int'(v), 55857);
        checkn("pin_beat4", exp_beat(16'd1, 16'd1, 4), pack2(34, 55));
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // basic run
        out_ready = 1'b1;
        pulse_start(1, 1, 5);
        for (int j = 0; j < 5; j++) begin
            check1("basic_valid", out_valid, 1'b1);
            checkn("basic_beat", out_num, pack2(basic_exp[2*j], basic_exp[2*j+1]));
            @(negedge clk);
        end
        check1("basic_end_valid", out_valid, 1'b0);
        check1("basic_end_done", done, 1'b1);
        check1("basic_end_ovf", overflow, 1'b0);

        // backpressure during beat 2
        n_xfer = 0;
        pulse_start(1, 1, 5);
        @(negedge clk);
        checkn("bp_beat2", out_num, pack2(2, 3));
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("bp_hold_valid", out_valid, 1'b1);
            checkn("bp_hold_num", out_num, pack2(2, 3));
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkn("bp_beat3", out_num, pack2(5, 8));
        wait_done(50);
        checki("bp_xfers", n_xfer, 5);

        // start during RUN is ignored
        n_xfer = 0;
        pulse_start(1, 1, 8);
        @(negedge clk);
        start = 1'b1; seed_a = 16'd5; seed_b = 16'd5; len = CNT_W'(3);
        @(negedge clk);
        start = 1'b0;
        checkn("ctl_ignored", out_num, pack2(5, 8));
        wait_done(50);
        checki("ctl_xfers", n_xfer, 8);
        pulse_start(0, 0, 2);
        checkn("zero_b0", out_num, pack2(0, 0));
        @(negedge clk);
        checkn("zero_b1", out_num, pack2(0, 0));
        @(negedge clk);
        check1("zero_done", done, 1'b1);
        check1("zero_valid", out_valid, 1'b0);
        check1("zero_ovf", overflow, 1'b0);

        // start coincident with last-beat transfer
        pulse_start(2, 3, 2);
        @(negedge clk);
        start = 1'b1; seed_a = 16'd7; seed_b = 16'd7; len = CNT_W'(9);
        @(negedge clk);
        start = 1'b0;
        check1("coinc_done", done, 1'b1);
        check1("coinc_valid", out_valid, 1'b0);

        // overflow on free run
        pulse_start(1, 1, 0);
        repeat (11) @(negedge clk);
        checkn("ovf_beat12", out_num, pack2(28657, 46368));
        check1("ovf_beat12_flag", overflow, 1'b0);
        @(negedge clk);
        if (SAT) checkn("ovf_beat13", out_num, pack2(65535, 65535));
        else     checkn("ovf_beat13", out_num, pack2(9489, 55857));
        check1("ovf_beat13_flag", overflow, 1'b1);
        @(negedge clk);
        if (SAT) begin
            check1("sat_done", done, 1'b1);
            check1("sat_valid", out_valid, 1'b0);
        end else begin
            repeat (10) @(negedge clk);
            check1("wrap_sticky", overflow, 1'b1);
            check1("wrap_running", out_valid, 1'b1);
        end
        reset_mid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("post_rst_valid", out_valid, 1'b0);
        end

        // randomized runs
        for (int r = 0; r < 20; r++) begin
            out_ready = 1'b1;
            pulse_start(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                        ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 10)));
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) begin
                    start  = 1'b1;
                    seed_a = W'($urandom);
                    seed_b = W'($urandom);
                    len    = CNT_W'($urandom_range(0, 6));
                end else begin
                    start = 1'b0;
                end
            end
            start = 1'b0;
            reset_mid();
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fib_stream_gen.md
Name: fib_stream_gen

Overview:
- Parametrised Fibonacci sequence generator with a valid/ready output stream.
- Emits LANES consecutive terms per accepted beat, starting from programmable seeds.
- Runs for a programmable number of beats, or free-running.
- Flags arithmetic overflow. Serves as a reusable stimulus/number source for sequential-basics exercises and benches.

Parameters:
- W, 16, width of each term in bits (legal range 4..32).
- LANES, 2, terms per beat (legal range 1..4).
- CNT_W, 16, width of the beat-length input and the beat counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; loads seeds and begins a sequence.
- seed_a  in  W  first term t0.
- seed_b  in  W  second term t1.
- len  in  CNT_W  number of beats to emit; 0 = free-running.
- out_ready  in  1  consumer ready.
- out_valid  out  1  beat available.
- out_num  out  LANES*W  lane i in bits [i*W +: W].
- overflow  out  1  sticky; a wrapped term has been presented.
- done  out  1  sequence complete.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; out_valid=0, out_num=0, overflow=0, done=0; internal terms and beat counter cleared. Outputs change immediately on rst falling, not at the next edge.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE when the last beat is accepted and len != 0.
  - DONE -> RUN on start.
  - RUN has no exit when len == 0 (except reset).
- start is sampled only in IDLE/DONE and is ignored in RUN. seed_a, seed_b and len are captured on the same edge as start.
- Latency: start sampled at edge N -> out_valid=1 from just after edge N, carrying t0..t(LANES-1). No bubbles between beats while out_ready=1.
- Term recurrence: t0=seed_a, t1=seed_b, tk = t(k-2) + t(k-1) mod 2^W. Lane i of beat j = t(j*LANES + i).
- LANES=1: one term per beat; lane 0 of beat j is tj.
- Next-beat state is computed by a chain of LANES W-bit adders within one cycle (no multicycle path).
- Handshake: a transfer occurs on an edge where out_valid && out_ready.
  - out_num must be held stable while out_valid=1 && out_ready=0.
  - out_valid must not drop without a transfer, except on reset.
- Beat counter increments per transfer.
  - len != 0: after the len-th transfer, out_valid=0, done=1 and state DONE on the same edge.
  - len == 0: the counter wraps silently and the generator never reaches DONE.
- done clears on the start edge that leaves DONE.
- overflow:
  - Sets together with the first presented beat that contains any term whose true value >= 2^W (carry out of any adder in its history).
  - Remains 1 until reset or the next accepted start.
  - Terms themselves wrap modulo 2^W.
- Seeds 0,0: all terms 0 and overflow never sets.
- Simultaneous start with the last-beat transfer: state is RUN at the time of that edge, so start is ignored and the block enters DONE.

Optional Feature:
- Macro: FIB_STREAM_SATURATE_EN.
- Defined:
  - On the first beat containing an overflowed term, that lane and all higher lanes read all-ones ({W{1'b1}}) and overflow=1.
  - After that beat transfers, the block enters DONE with done=1, regardless of len.
- Not defined: wrap-around behaviour as specified above; the generator keeps running.

Test Plan:
- Basic run: W=16, LANES=2, seeds 1,1, len=5, out_ready=1 -> beats (1,1) (2,3) (5,8) (13,21) (34,55). Then out_valid=0, done=1, overflow=0.
- Backpressure: same setup, out_ready=0 for 3 cycles during beat 2 -> out_num holds (2,3) with out_valid=1. Beat 3 (5,8) appears only after the transfer, and the beat count is still 5.
- Overflow, wrap: W=16, LANES=2, seeds 1,1, len=0 -> beat 12 is (28657,46368) with overflow=0. Beat 13 is (9489,55857) with overflow=1, and overflow stays 1 thereafter.
- Overflow, saturate (FIB_STREAM_SATURATE_EN): same stimulus -> beat 13 is (65535,65535) with overflow=1. After its transfer, done=1 and out_valid=0.
- Control: start pulsed mid-RUN with seeds 5,5 -> ignored, sequence continues unchanged. In DONE, start with seeds 0,0 and len=2 -> beats (0,0) (0,0), then done=1.
- Async reset: drive rst low between clock edges during RUN -> out_valid, out_num, overflow and done go to 0 immediately. After release, no out_valid until start.
